// File: rtl/ifetch_stage_pkg.sv
// Shared pipeline definitions: reset/bubble constants, IF/ID bundle, fetch states.
package ifetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    // An empty pipeline slot: NOP word, zero addresses, not valid.
    function automatic if_id_t make_bubble(input logic [31:0] nop_word);
        if_id_t b;
        b.instr = nop_word;
        b.pc    = 32'h0;
        b.pc4   = 32'h0;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/ifetch_stage_if.sv
// Instruction ROM bus: word address out from fetch, instruction word back.
interface ifetch_stage_if #(
    parameter int ROM_AW = 10
);
    logic [ROM_AW-1:0] rom_addr;
    logic [31:0]       rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/ifetch_stage_if_id_reg.sv
// IF/ID pipeline register with load, hold and bubble controls.
module if_id_reg
    import ifetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   bubble,
    input  if_id_t d,
    output if_id_t q
);

    // Reset and bubble both empty the slot; bubble beats load; otherwise hold.
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            q <= make_bubble(NOP_INSTR);
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ifetch_stage.sv
// Fetch stage: PC register, next-PC selection, RUN/HALT control, fetch counter.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  RUN   | fetching; redirect > halt_req > stall > advance each edge
//  HALT  | frozen after a halt from decode; only rst leaves this state
module ifetch_stage
    import ifetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter int          ROM_AW    = 10,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    input  logic                 halt_req,
    ifetch_stage_if.master       rom,
    output logic [31:0]          pc,
    output logic [31:0]          id_instr,
    output logic [31:0]          id_pc,
    output logic [31:0]          id_pc4,
    output logic                 id_valid,
    output logic                 halted,
    output logic [31:0]          fetch_count
);

    fetch_state_e state, state_next;
    logic [31:0]  pc_next;
    logic [31:0]  pc_plus4;
    logic         ifid_load;
    logic         ifid_bubble;
    logic         count_inc;
    if_id_t       ifid_d;
    if_id_t       ifid_q;

    // Fetch index wraps inside the ROM; pc itself keeps all 32 bits.
    assign rom.rom_addr = pc[ROM_AW+1:2];
    assign pc_plus4     = pc + 32'd4;

    assign ifid_d.instr = rom.rom_data;
    assign ifid_d.pc    = pc;
    assign ifid_d.pc4   = pc_plus4;
    assign ifid_d.valid = 1'b1;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state, next PC and IF/ID control. Redirect wins over halt because
    // the halting instruction in ID is on the wrong path.
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        count_inc   = 1'b0;
        case (state)
            RUN: begin
                if (redirect) begin
                    pc_next     = redirect_pc & 32'hFFFF_FFFC;
                    ifid_bubble = 1'b1;
                end else if (halt_req) begin
                    ifid_bubble = 1'b1;
                    state_next  = HALT;
                end else if (!stall) begin
                    pc_next   = pc_plus4;
                    ifid_load = 1'b1;
                    count_inc = 1'b1;
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Program counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    // Count of instructions accepted into IF/ID, wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= 32'h0;
        end else if (count_inc) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk    (clk),
        .rst    (rst),
        .load   (ifid_load),
        .bubble (ifid_bubble),
        .d      (ifid_d),
        .q      (ifid_q)
    );

    assign id_instr = ifid_q.instr;
    assign id_pc    = ifid_q.pc;
    assign id_pc4   = ifid_q.pc4;
    assign id_valid = ifid_q.valid;
    assign halted   = (state == HALT);

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage with a behavioural ROM.
module tb_ifetch_stage;
    import ifetch_stage_pkg::*;

    localparam int ROM_AW = 10;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic [31:0] pc;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic        halted;
    logic [31:0] fetch_count;

    int n_total;
    int n_bad;

    logic [31:0] rom_mem [0:(1<<ROM_AW)-1];

    ifetch_stage_if #(.ROM_AW(ROM_AW)) rom_bus ();

    ifetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .ROM_AW    (ROM_AW),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt_req    (halt_req),
        .rom         (rom_bus.master),
        .pc          (pc),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pc4      (id_pc4),
        .id_valid    (id_valid),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    // Zero-latency ROM.
    always_comb rom_bus.rom_data = rom_mem[rom_bus.rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] e_instr,
                            input logic [31:0] e_pc, input logic [31:0] e_pc4,
                            input logic e_valid);
        chk({tag, ".instr"}, id_instr, e_instr);
        chk({tag, ".id_pc"}, id_pc, e_pc);
        chk({tag, ".pc4"}, id_pc4, e_pc4);
        chk({tag, ".valid"}, {31'h0, id_valid}, {31'h0, e_valid});
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        for (int i = 0; i < (1 << ROM_AW); i++) rom_mem[i] = 32'hA000_0000 | i;
        rom_mem[0] = 32'h2008_0001;
        rom_mem[1] = 32'h2009_0002;
        rom_mem[2] = 32'h010A_5020;

        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; halt_req = 1'b0;
        step();
        step();
        chk("rst.pc", pc, 32'h0);
        chk("rst.rom_addr", {22'h0, rom_bus.rom_addr}, 32'h0);
        chk_ifid("rst", 32'h0, 32'h0, 32'h0, 1'b0);
        chk("rst.count", fetch_count, 32'h0);
        chk("rst.halted", {31'h0, halted}, 32'h0);

        // Free run: two instructions in, then stall while id_pc=0x4.
        rst = 1'b0;
        step();
        chk_ifid("run0", 32'h2008_0001, 32'h0, 32'h4, 1'b1);
        chk("run0.pc", pc, 32'h4);
        step();
        chk_ifid("run1", 32'h2009_0002, 32'h4, 32'h8, 1'b1);
        chk("run1.pc", pc, 32'h8);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall.pc", pc, 32'h8);
            chk_ifid("stall", 32'h2009_0002, 32'h4, 32'h8, 1'b1);
            chk("stall.count", fetch_count, 32'h2);
        end
        stall = 1'b0;
        step();
        chk_ifid("run2", 32'h010A_5020, 32'h8, 32'hC, 1'b1);
        chk("run2.pc", pc, 32'hC);
        chk("run2.count", fetch_count, 32'h3);

        // Redirect with stall in the same cycle: low bits dropped, one bubble.
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0043;
        step();
        chk("redir.pc", pc, 32'h40);
        chk_ifid("redir", 32'h0, 32'h0, 32'h0, 1'b0);
        chk("redir.count", fetch_count, 32'h3);
        stall = 1'b0; redirect = 1'b0;
        step();
        chk_ifid("redir_tgt", 32'hA000_0010, 32'h40, 32'h44, 1'b1);
        chk("redir_tgt.pc", pc, 32'h44);
        chk("redir_tgt.count", fetch_count, 32'h4);

        // Halt and redirect together: redirect wins, stage stays running.
        halt_req = 1'b1; redirect = 1'b1; redirect_pc = 32'h20;
        step();
        chk("hr.halted", {31'h0, halted}, 32'h0);
        chk("hr.pc", pc, 32'h20);
        chk("hr.valid", {31'h0, id_valid}, 32'h0);
        halt_req = 1'b0; redirect = 1'b0;
        step();
        chk_ifid("hr_tgt", 32'hA000_0008, 32'h20, 32'h24, 1'b1);
        chk("hr_tgt.count", fetch_count, 32'h5);

        // Halt at pc=0x10, then everything but rst is ignored.
        redirect = 1'b1; redirect_pc = 32'h10;
        step();
        redirect = 1'b0; halt_req = 1'b1;
        step();
        chk("halt.halted", {31'h0, halted}, 32'h1);
        chk("halt.pc", pc, 32'h10);
        chk("halt.valid", {31'h0, id_valid}, 32'h0);
        halt_req = 1'b0; redirect = 1'b1; redirect_pc = 32'h80; stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("halted.pc", pc, 32'h10);
            chk("halted.halted", {31'h0, halted}, 32'h1);
            chk("halted.valid", {31'h0, id_valid}, 32'h0);
            chk("halted.count", fetch_count, 32'h5);
        end
        stall = 1'b0; redirect = 1'b0;
        step();
        chk("halted_free.pc", pc, 32'h10);
        rst = 1'b1; redirect = 1'b1;
        step();
        chk("halt_rst.pc", pc, 32'h0);
        chk("halt_rst.halted", {31'h0, halted}, 32'h0);
        chk("halt_rst.count", fetch_count, 32'h0);
        rst = 1'b0; redirect = 1'b0;

        // ROM index wrap at the top of the ROM span.
        redirect = 1'b1; redirect_pc = 32'h0000_0FF8;
        step();
        redirect = 1'b0;
        step();
        chk("wrap.pc", pc, 32'hFFC);
        chk("wrap.rom_addr", {22'h0, rom_bus.rom_addr}, 32'h3FF);
        step();
        chk("wrap2.pc", pc, 32'h1000);
        chk("wrap2.rom_addr", {22'h0, rom_bus.rom_addr}, 32'h0);
        chk_ifid("wrap2", 32'hA000_03FF, 32'hFFC, 32'h1000, 1'b1);
        step();
        chk_ifid("wrap3", 32'h2008_0001, 32'h1000, 32'h1004, 1'b1);
        chk("wrap3.count", fetch_count, 32'h3);

        // 32-bit pc wrap.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        step();
        chk("pcwrap.pc", pc, 32'hFFFF_FFFC);
        redirect = 1'b0;
        step();
        chk("pcwrap2.pc", pc, 32'h0);
        chk("pcwrap2.pc4", id_pc4, 32'h0);
        chk("pcwrap2.id_pc", id_pc, 32'hFFFF_FFFC);

        // Counter wrap from a preset value near the top.
        stall = 1'b1;
        force dut.fetch_count = 32'hFFFF_FFFE;
        step();
        release dut.fetch_count;
        #1;
        chk("cnt.preset", fetch_count, 32'hFFFF_FFFE);
        stall = 1'b0;
        step();
        chk("cnt.max", fetch_count, 32'hFFFF_FFFF);
        step();
        chk("cnt.wrap", fetch_count, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ifetch_stage.md
# ifetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline. Holds the program counter, drives the word address of the combinational instruction ROM, and captures the returned 32-bit instruction into the IF/ID pipeline register for decode. Handles the decode-stage load-use stall, the EX-stage branch/jump redirect with IF/ID squash, and a sticky halt raised by decode.

## Interface
- RESET_PC, 32'h0000_0000, byte address loaded into PC on reset
- ROM_AW, 10, ROM word-address width; ROM span is 4·2^ROM_AW bytes
- NOP_INSTR, 32'h0000_0000, instruction word placed in IF/ID on a bubble
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold PC and IF/ID, from the decode hazard unit
- redirect  in  1  taken branch or jump resolved in EX
- redirect_pc  in  32  target byte address, valid when redirect=1
- halt_req  in  1  decode has a halt/syscall-exit instruction in ID
- rom_addr  out  ROM_AW  word address to ROM, equal to pc[ROM_AW+1:2]
- rom_data  in  32  instruction word returned combinationally by ROM
- pc  out  32  current fetch byte address
- id_instr  out  32  IF/ID instruction
- id_pc  out  32  IF/ID address of id_instr
- id_pc4  out  32  IF/ID id_pc+4
- id_valid  out  1  IF/ID holds a real instruction; 0 = bubble
- halted  out  1  stage is in HALT state
- fetch_count  out  32  number of instructions accepted into IF/ID

## Operation
- States: RUN, HALT. Reset → RUN. RUN → HALT when halt_req=1 and redirect=0. HALT → RUN only on rst.
- Per-edge priority in RUN: rst > redirect > halt_req > stall > advance.
- rst: pc←RESET_PC, IF/ID←bubble (id_instr=NOP_INSTR, id_pc=0, id_pc4=0, id_valid=0), fetch_count←0, halted←0.
- redirect: pc←{redirect_pc[31:2],2'b00} (low bits forced 0); IF/ID←bubble. Overrides stall and halt_req (instruction in ID is on the wrong path).
- halt_req (no redirect): pc held; IF/ID←bubble; state←HALT.
- stall (no redirect, no halt_req): pc, IF/ID, fetch_count all held.
- advance: IF/ID←{rom_data, pc, pc+4, valid=1}; pc←pc+4; fetch_count←fetch_count+1.
- HALT: pc, IF/ID (bubble), fetch_count frozen; stall/redirect/halt_req ignored.
- Arithmetic: pc+4 is 32-bit modulo 2^32. rom_addr uses only pc[ROM_AW+1:2], so fetch wraps to word 0 past byte 4·2^ROM_AW−4; pc itself is not truncated.
- fetch_count wraps 0xFFFF_FFFF → 0.

## Timing
- rom_addr is combinational from pc; ROM read has zero latency; instruction at pc appears on id_instr one edge later (latency 1).
- First valid instruction: id_valid=1 on the second edge after rst deasserts is not required; it is the first edge with rst=0 and stall=0.
- Redirect: target's instruction enters IF/ID on the edge after the redirect edge; exactly one bubble is inserted.
- Stall held N cycles freezes all outputs for N cycles, then resumes with no lost or duplicated instruction.
- rst asserted mid-stall, mid-redirect or in HALT takes effect at that edge regardless of other inputs.

## Structure
- Shared pipeline package: RESET_PC default, NOP_INSTR, IF/ID bundle typedef (instr, pc, pc4, valid), state enum {RUN, HALT}.
- One sub-module: if_id_reg (IF/ID register with load/hold/bubble controls, synchronous reset); PC, next-PC mux, FSM and counter in ifetch_stage.

## Test plan
- Reset then free-run with ROM words 0x2008_0001, 0x2009_0002, 0x010A_5020 → id_instr sequence in order, id_pc 0x0,0x4,0x8, id_pc4 0x4,0x8,0xC, fetch_count 3.
- stall=1 for 3 cycles while id_pc=0x4 → pc stays 0x8, id_instr/id_pc unchanged; after release id_pc=0x8 next edge, no duplicate.
- redirect=1, redirect_pc=0x0000_0043 with stall=1 same cycle → pc=0x40, one bubble (id_valid=0, id_instr=0), then id_pc=0x40.
- halt_req=1 at pc=0x10 → halted=1, pc stays 0x10, id_valid=0 forever; later redirect/stall ignored; rst → pc=0x0, halted=0.
- halt_req and redirect same cycle (target 0x20) → state RUN, pc=0x20, bubble, fetch resumes.
- Run pc to 0xFFC (ROM_AW=10) → rom_addr=0x3FF, next pc=0x1000 with rom_addr=0x000; fetch_count preset near 0xFFFF_FFFF wraps to 0.
